ifft8_seq: RTL and testbench

//  8-point radix-2 DIT inverse FFT; complex 9-bit fixed point; one shared butterfly.

---
 rtl/fft_pkg.sv | 62 ++++++
 rtl/ifft8_seq_if.sv | 26 ++
 rtl/ifft8_seq_bfly.sv | 39 +++
 rtl/ifft8_seq.sv | 121 ++++++++++++
 tb/tb_ifft8_seq.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types, twiddle ROM and arithmetic helpers for the 8-point IFFT.
// Scaling option (see ifft_bfly) is selected by the IFFT_STAGE_SCALE_EN macro.
package fft_pkg;
    localparam int DW      = 9;
    localparam int TW_FRAC = 7;
    localparam int SW      = DW + 2;
    localparam int PW      = 2 * DW;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [SW-1:0] wide_t;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_FRAC - 1));

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Conjugate twiddles W^-k = cos + j*sin, scaled by 2^TW_FRAC.
    function automatic sample_t tw_re(input logic [1:0] k);
        sample_t v;
        case (k)
            2'd0:    v = sample_t'(128);
            2'd1:    v = sample_t'(91);
            2'd2:    v = sample_t'(0);
            default: v = sample_t'(-91);
        endcase
        return v;
    endfunction

    function automatic sample_t tw_im(input logic [1:0] k);
        sample_t v;
        case (k)
            2'd0:    v = sample_t'(0);
            2'd1:    v = sample_t'(91);
            2'd2:    v = sample_t'(128);
            default: v = sample_t'(91);
        endcase
        return v;
    endfunction

    function automatic wide_t mul_rnd(input sample_t w, input sample_t x);
        logic signed [PW-1:0] p;
        p = PW'(w) * PW'(x) + RND;
        return SW'(p >>> TW_FRAC);
    endfunction

    // Clamp to the DW-bit range; in range when the top three bits agree.
    function automatic sample_t sat_dw(input wide_t v);
        sample_t r;
        if (v[SW-1:DW-1] == 3'b000 || v[SW-1:DW-1] == 3'b111)
            r = v[DW-1:0];
        else if (v[SW-1])
            r = {1'b1, {(DW-1){1'b0}}};
        else
            r = {1'b0, {(DW-1){1'b1}}};
        return r;
    endfunction
endpackage

// File: rtl/ifft8_seq_if.sv
// Streaming bin-in / sample-out bundle for ifft8_seq.
interface ifft8_seq_if;
    import fft_pkg::*;

    logic       in_valid;
    logic       in_ready;
    sample_t    in_re;
    sample_t    in_im;
    logic       out_valid;
    logic       out_ready;
    sample_t    out_re;
    sample_t    out_im;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
    );
endinterface

// File: rtl/ifft8_seq_bfly.sv
// Combinational radix-2 butterfly: rounded twiddle multiply, add/sub, optional >>>1, saturate.
// IFFT_STAGE_SCALE_EN enables the per-stage halving.
module ifft_bfly
    import fft_pkg::*;
(
    input  sample_t i_a_re,
    input  sample_t i_a_im,
    input  sample_t i_b_re,
    input  sample_t i_b_im,
    input  sample_t i_w_re,
    input  sample_t i_w_im,
    output sample_t o_a_re,
    output sample_t o_a_im,
    output sample_t o_b_re,
    output sample_t o_b_im
);
    wide_t w_t_re, w_t_im;
    wide_t w_sa_re, w_sa_im, w_sb_re, w_sb_im;

    assign w_t_re  = mul_rnd(i_w_re, i_b_re) - mul_rnd(i_w_im, i_b_im);
    assign w_t_im  = mul_rnd(i_w_re, i_b_im) + mul_rnd(i_w_im, i_b_re);

    assign w_sa_re = SW'(i_a_re) + w_t_re;
    assign w_sa_im = SW'(i_a_im) + w_t_im;
    assign w_sb_re = SW'(i_a_re) - w_t_re;
    assign w_sb_im = SW'(i_a_im) - w_t_im;

`ifdef IFFT_STAGE_SCALE_EN
    assign o_a_re = sat_dw(w_sa_re >>> 1);
    assign o_a_im = sat_dw(w_sa_im >>> 1);
    assign o_b_re = sat_dw(w_sb_re >>> 1);
    assign o_b_im = sat_dw(w_sb_im >>> 1);
`else
    assign o_a_re = sat_dw(w_sa_re);
    assign o_a_im = sat_dw(w_sa_im);
    assign o_b_re = sat_dw(w_sb_re);
    assign o_b_im = sat_dw(w_sb_im);
`endif
endmodule

// File: rtl/ifft8_seq.sv
// Iterative 8-point radix-2 DIT inverse FFT with a single shared butterfly.
// Define IFFT_STAGE_SCALE_EN for the true (1/8-scaled) IFFT; otherwise output is 8*IFFT.
module ifft8_seq
    import fft_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst,
    ifft8_seq_if.slave  bus
);
    logic [1:0] r_state;
    logic [2:0] r_load_cnt;
    logic [3:0] r_cnt;
    logic [2:0] r_out_idx;
    sample_t    r_re [0:7];
    sample_t    r_im [0:7];

    logic       w_in_fire, w_out_fire, w_out_valid;
    logic [1:0] w_stage, w_j, w_tw;
    logic [2:0] w_a_idx, w_b_idx;
    sample_t    w_na_re, w_na_im, w_nb_re, w_nb_im;

    assign w_out_valid = (r_state == ST_UNLOAD);
    assign w_in_fire   = bus.in_valid && (r_state == ST_LOAD);
    assign w_out_fire  = w_out_valid && bus.out_ready;
    assign w_stage     = r_cnt[3:2];
    assign w_j         = r_cnt[1:0];

    // Butterfly j of stage s pairs (a, a+2^s); twiddle index is (j mod 2^s)*(4>>s).
    always_comb begin
        w_a_idx = {w_j, 1'b0};
        w_b_idx = {w_j, 1'b1};
        w_tw    = 2'd0;
        case (w_stage)
            2'd0: begin
                w_a_idx = {w_j, 1'b0};
                w_b_idx = {w_j, 1'b1};
                w_tw    = 2'd0;
            end
            2'd1: begin
                w_a_idx = {w_j[1], 1'b0, w_j[0]};
                w_b_idx = {w_j[1], 1'b1, w_j[0]};
                w_tw    = {w_j[0], 1'b0};
            end
            default: begin
                w_a_idx = {1'b0, w_j};
                w_b_idx = {1'b1, w_j};
                w_tw    = w_j;
            end
        endcase
    end

    ifft_bfly u_bfly (
        .i_a_re (r_re[w_a_idx]),
        .i_a_im (r_im[w_a_idx]),
        .i_b_re (r_re[w_b_idx]),
        .i_b_im (r_im[w_b_idx]),
        .i_w_re (tw_re(w_tw)),
        .i_w_im (tw_im(w_tw)),
        .o_a_re (w_na_re),
        .o_a_im (w_na_im),
        .o_b_re (w_nb_re),
        .o_b_im (w_nb_im)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= ST_LOAD;
            r_load_cnt <= 3'd0;
            r_cnt      <= 4'd0;
            r_out_idx  <= 3'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_load_cnt <= r_load_cnt + 3'd1;
                        if (r_load_cnt == 3'd7) begin
                            r_state <= ST_COMPUTE;
                            r_cnt   <= 4'd0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd11) begin
                        r_state <= ST_UNLOAD;
                        r_cnt   <= 4'd0;
                    end
                end
                ST_UNLOAD: begin
                    if (w_out_fire) begin
                        r_out_idx <= r_out_idx + 3'd1;
                        if (r_out_idx == 3'd7)
                            r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Sample RAM: bit-reversed load, then in-place butterfly writeback.
    always_ff @(posedge clk_in) begin
        if (w_in_fire) begin
            r_re[bitrev3(r_load_cnt)] <= bus.in_re;
            r_im[bitrev3(r_load_cnt)] <= bus.in_im;
        end else if (r_state == ST_COMPUTE) begin
            r_re[w_a_idx] <= w_na_re;
            r_im[w_a_idx] <= w_na_im;
            r_re[w_b_idx] <= w_nb_re;
            r_im[w_b_idx] <= w_nb_im;
        end
    end

    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.out_valid = w_out_valid;
    assign bus.out_re    = w_out_valid ? r_re[r_out_idx] : '0;
    assign bus.out_im    = w_out_valid ? r_im[r_out_idx] : '0;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = w_out_valid && (r_out_idx == 3'd7);
    assign bus.busy      = (r_state != ST_LOAD);
endmodule

// File: tb/tb_ifft8_seq.sv
// Directed self-checking bench for ifft8_seq; expected values follow IFFT_STAGE_SCALE_EN.
module tb_ifft8_seq;
    import fft_pkg::*;

    logic clk_in = 1'b0;
    logic rst;
    always #5 clk_in = ~clk_in;

    ifft8_seq_if bus();

    ifft8_seq dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int st_re [8], st_im [8], exp_re [8], exp_im [8], got_re [8], got_im [8];
    int lat, n_got, send_to, order_err, stable_err, last_err, ready_err;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_stim();
        for (int k = 0; k < 8; k++) begin
            st_re[k] = 0; st_im[k] = 0; exp_re[k] = 0; exp_im[k] = 0;
        end
    endtask

    task automatic send_frame();
        send_to = 0;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re    = sample_t'(st_re[k]);
            bus.in_im    = sample_t'(st_im[k]);
            for (int w = 0; w < 60 && bus.in_ready !== 1'b1; w++) begin
                @(posedge clk_in); #1;
            end
            if (bus.in_ready !== 1'b1) send_to++;
            @(posedge clk_in); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk_in); #1;
            lat++;
        end
    endtask

    task automatic recv_frame(input bit bp);
        int c;
        bit stalled;
        int s_re, s_im, s_idx;
        n_got = 0; c = 0; stalled = 0; s_re = 0; s_im = 0; s_idx = 0;
        order_err = 0; stable_err = 0; last_err = 0; ready_err = 0;
        while (n_got < 8 && c < 200) begin
            bus.out_ready = bp ? pat[c % 4] : 1'b1;
            @(negedge clk_in);
            if (bus.out_valid === 1'b1) begin
                if (bus.in_ready !== 1'b0) ready_err++;
                if (stalled && (int'(bus.out_re) != s_re || int'(bus.out_im) != s_im
                                || int'(bus.out_idx) != s_idx))
                    stable_err++;
                if (bus.out_last !== (bus.out_idx == 3'd7)) last_err++;
                if (bus.out_ready) begin
                    if (int'(bus.out_idx) != n_got) order_err++;
                    got_re[n_got] = int'(bus.out_re);
                    got_im[n_got] = int'(bus.out_im);
                    n_got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    s_re = int'(bus.out_re); s_im = int'(bus.out_im); s_idx = int'(bus.out_idx);
                end
            end
            @(posedge clk_in); #1;
            c++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset out_last: got %b expected 0", bus.out_last); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %b expected 0", bus.busy); end
        checks++; if (bus.out_re !== 9'd0 || bus.out_im !== 9'd0) begin failures++; $display("[TB] FAIL reset out_re/im: got %0d/%0d expected 0/0", bus.out_re, bus.out_im); end
        checks++; if (bus.out_idx !== 3'd0) begin failures++; $display("[TB] FAIL reset out_idx: got %0d expected 0", bus.out_idx); end
        rst = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic test_impulse();
        clear_stim();
        st_re[0] = 64;
`ifdef IFFT_STAGE_SCALE_EN
        for (int n = 0; n < 8; n++) exp_re[n] = 8;
`else
        for (int n = 0; n < 8; n++) exp_re[n] = 64;
`endif
        send_frame();
        checks++; if (send_to != 0) begin failures++; $display("[TB] FAIL impulse load: %0d bins timed out, expected 0", send_to); end
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL impulse compute flags: busy=%b in_ready=%b expected 1/0", bus.busy, bus.in_ready); end
        wait_out();
        checks++; if (lat != 12) begin failures++; $display("[TB] FAIL impulse latency: got %0d expected 12", lat); end
        recv_frame(1'b0);
        checks++; if (n_got != 8) begin failures++; $display("[TB] FAIL impulse count: got %0d expected 8", n_got); end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got_re[n] != exp_re[n] || got_im[n] != exp_im[n]) begin
                failures++;
                $display("[TB] FAIL impulse x[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, got_re[n], got_im[n], exp_re[n], exp_im[n]);
            end
        end
    endtask

    task automatic test_alternating();
        clear_stim();
        st_re[0] = 32; st_re[4] = 32;
`ifdef IFFT_STAGE_SCALE_EN
        for (int n = 0; n < 8; n += 2) exp_re[n] = 8;
`else
        for (int n = 0; n < 8; n += 2) exp_re[n] = 64;
`endif
        send_frame();
        wait_out();
        checks++; if (lat != 12) begin failures++; $display("[TB] FAIL alternating latency: got %0d expected 12", lat); end
        recv_frame(1'b0);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got_re[n] != exp_re[n] || got_im[n] != exp_im[n]) begin
                failures++;
                $display("[TB] FAIL alternating x[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, got_re[n], got_im[n], exp_re[n], exp_im[n]);
            end
        end
    endtask

    task automatic set_tone();
        int tr [8], ti [8];
        clear_stim();
        st_re[1] = 128;
`ifdef IFFT_STAGE_SCALE_EN
        tr = '{16, 11, 0, -12, -16, -12, 0, 11};
        ti = '{0, 11, 16, 11, 0, -12, -16, -12};
`else
        tr = '{128, 91, 0, -91, -128, -91, 0, 91};
        ti = '{0, 91, 128, 91, 0, -91, -128, -91};
`endif
        for (int n = 0; n < 8; n++) begin exp_re[n] = tr[n]; exp_im[n] = ti[n]; end
    endtask

    task automatic test_tone();
        set_tone();
        send_frame();
        wait_out();
        recv_frame(1'b0);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got_re[n] != exp_re[n] || got_im[n] != exp_im[n]) begin
                failures++;
                $display("[TB] FAIL tone x[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, got_re[n], got_im[n], exp_re[n], exp_im[n]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_stim();
        for (int k = 0; k < 8; k++) st_re[k] = 200;
`ifdef IFFT_STAGE_SCALE_EN
        exp_re[0] = 200;
`else
        exp_re[0] = 255;
`endif
        send_frame();
        wait_out();
        recv_frame(1'b0);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got_re[n] != exp_re[n] || got_im[n] != exp_im[n]) begin
                failures++;
                $display("[TB] FAIL saturation x[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, got_re[n], got_im[n], exp_re[n], exp_im[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        set_tone();
        send_frame();
        bus.in_valid = 1'b1;
        bus.in_re = sample_t'(99);
        bus.in_im = sample_t'(-99);
        wait_out();
        checks++; if (lat != 12) begin failures++; $display("[TB] FAIL backpressure latency: got %0d expected 12", lat); end
        recv_frame(1'b1);
        bus.in_valid = 1'b0;
        checks++; if (n_got != 8) begin failures++; $display("[TB] FAIL backpressure count: got %0d expected 8", n_got); end
        checks++; if (order_err != 0) begin failures++; $display("[TB] FAIL backpressure order: %0d errors, expected 0", order_err); end
        checks++; if (stable_err != 0) begin failures++; $display("[TB] FAIL backpressure stall stability: %0d errors, expected 0", stable_err); end
        checks++; if (last_err != 0) begin failures++; $display("[TB] FAIL backpressure out_last: %0d errors, expected 0", last_err); end
        checks++; if (ready_err != 0) begin failures++; $display("[TB] FAIL backpressure in_ready during unload: %0d errors, expected 0", ready_err); end
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL backpressure return to load: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got_re[n] != exp_re[n] || got_im[n] != exp_im[n]) begin
                failures++;
                $display("[TB] FAIL backpressure x[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, got_re[n], got_im[n], exp_re[n], exp_im[n]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_tone();
        send_frame();
        repeat (5) @(posedge clk_in);
        #1;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL midreset pre busy: got %b expected 1", bus.busy); end
        rst = 1'b1;
        @(posedge clk_in); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset flags: in_ready=%b out_valid=%b busy=%b expected 1/0/0", bus.in_ready, bus.out_valid, bus.busy);
        end
        rst = 1'b0;
        @(posedge clk_in); #1;
        clear_stim();
        st_re[0] = 64;
`ifdef IFFT_STAGE_SCALE_EN
        for (int n = 0; n < 8; n++) exp_re[n] = 8;
`else
        for (int n = 0; n < 8; n++) exp_re[n] = 64;
`endif
        send_frame();
        wait_out();
        checks++; if (lat != 12) begin failures++; $display("[TB] FAIL midreset latency: got %0d expected 12", lat); end
        recv_frame(1'b0);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got_re[n] != exp_re[n] || got_im[n] != exp_im[n]) begin
                failures++;
                $display("[TB] FAIL midreset x[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, got_re[n], got_im[n], exp_re[n], exp_im[n]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_impulse();
        test_alternating();
        test_tone();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
